// File: rtl/stat_stream_calc_if.sv
// ---------------------------------------------------------------------------
// stat_stream_calc_if
//
// Bundles the sample stream and the result stream of the statistics engine.
//
// Sample side  : in_valid / in_ready handshake carrying in_data, plus the
//                statistic select op (sampled with the first sample only).
// Result side  : out_valid / out_ready handshake carrying result and the
//                one-hot tag max_f / min_f / mean_f / var_f.
//
// Modports
//    master : producer of samples and consumer of results (e.g. a testbench)
//    slave  : the statistics engine itself
// ---------------------------------------------------------------------------
interface stat_stream_calc_if #(
   parameter int WIDTH = 4
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [3:0]           op;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 max_f;
   logic                 min_f;
   logic                 mean_f;
   logic                 var_f;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output op,
      input  out_valid,
      output out_ready,
      input  result,
      input  max_f,
      input  min_f,
      input  mean_f,
      input  var_f
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  op,
      output out_valid,
      input  out_ready,
      output result,
      output max_f,
      output min_f,
      output mean_f,
      output var_f
   );

endinterface

// File: rtl/stat_stream_calc.sv
// ---------------------------------------------------------------------------
// stat_stream_calc
//
// Streaming statistics engine. Collects a frame of COUNT unsigned samples,
// tracks max, min, sum and sum-of-squares, then presents one selected
// statistic (Max, Min, Mean or Var) with a one-hot tag on the result port.
//
// Parameters
//    WIDTH : sample width in bits (>= 2)
//    COUNT : samples per frame (power of two, >= 2)
//
// Ports
//    clk    : rising-edge clock
//    rst_n  : asynchronous active-low reset
//    bus_io : slave side of stat_stream_calc_if (sample + result streams)
// ---------------------------------------------------------------------------
module stat_stream_calc #(
   parameter int WIDTH = 4,
   parameter int COUNT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   stat_stream_calc_if.slave      bus_io
);

   localparam int LOG2N = $clog2(COUNT);
   localparam int SUM_W = WIDTH + LOG2N;
   localparam int SQ_W  = 2*WIDTH + LOG2N;
   localparam int VAR_W = 2*WIDTH + 2*LOG2N;
   localparam int CNT_W = LOG2N + 1;
   localparam int RES_W = 2*WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      CALC,
      DONE
   } state_t;

   state_t             state_q, state_d;

   logic [WIDTH-1:0]   maxAcc_q, maxAcc_d;
   logic [WIDTH-1:0]   minAcc_q, minAcc_d;
   logic [SUM_W-1:0]   sumAcc_q, sumAcc_d;
   logic [SQ_W-1:0]    sqAcc_q, sqAcc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [3:0]         op_q, op_d;

   logic [WIDTH-1:0]   maxStat_q, maxStat_d;
   logic [WIDTH-1:0]   minStat_q, minStat_d;
   logic [WIDTH-1:0]   meanStat_q, meanStat_d;
   logic [RES_W-1:0]   varStat_q, varStat_d;

   logic               inHandshake;
   logic               lastSample;
   logic [RES_W-1:0]   sampleExt;
   logic [RES_W-1:0]   sampleSq;
   logic [VAR_W-1:0]   scaledSq;
   logic [VAR_W-1:0]   sumExt;
   logic [VAR_W-1:0]   sumSquared;
   logic [VAR_W-1:0]   varFull;

   // Handshake and frame-end detection; in_ready is low outside IDLE/ACCUM,
   // so samples offered during CALC or DONE never qualify.
   assign inHandshake = bus_io.in_valid & bus_io.in_ready;
   assign lastSample  = (count_q == CNT_W'(COUNT - 1));

   // Square of the incoming sample, computed at full 2*WIDTH precision.
   assign sampleExt = {{WIDTH{1'b0}}, bus_io.in_data};
   assign sampleSq  = sampleExt * sampleExt;

   // Variance numerator COUNT*sumsq - sum^2. Multiplying by COUNT is a left
   // shift by LOG2N. The difference is never negative (Cauchy-Schwarz), and
   // after dividing by COUNT^2 it always fits in 2*WIDTH bits, so taking the
   // slice above the low 2*LOG2N bits gives the floored variance exactly.
   assign scaledSq   = {sqAcc_q, {LOG2N{1'b0}}};
   assign sumExt     = {{(VAR_W-SUM_W){1'b0}}, sumAcc_q};
   assign sumSquared = sumExt * sumExt;
   assign varFull    = scaledSq - sumSquared;

   // State register for the frame-control FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept COUNT samples, spend one cycle computing,
   // then hold the result until the consumer takes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (inHandshake) state_d = ACCUM;
         ACCUM: if (inHandshake && lastSample) state_d = CALC;
         CALC:  state_d = DONE;
         DONE:  if (bus_io.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: the sample port is open only while collecting a frame,
   // and the result port is valid only in DONE.
   always_comb begin
      bus_io.in_ready  = 1'b0;
      bus_io.out_valid = 1'b0;
      case (state_q)
         IDLE:    bus_io.in_ready  = 1'b1;
         ACCUM:   bus_io.in_ready  = 1'b1;
         CALC:    bus_io.in_ready  = 1'b0;
         DONE:    bus_io.out_valid = 1'b1;
         default: bus_io.in_ready  = 1'b0;
      endcase
   end

   // Datapath next-state: the first sample of a frame seeds every
   // accumulator and captures op; later samples fold into the running
   // values; CALC turns the accumulators into the four statistics.
   always_comb begin
      maxAcc_d   = maxAcc_q;
      minAcc_d   = minAcc_q;
      sumAcc_d   = sumAcc_q;
      sqAcc_d    = sqAcc_q;
      count_d    = count_q;
      op_d       = op_q;
      maxStat_d  = maxStat_q;
      minStat_d  = minStat_q;
      meanStat_d = meanStat_q;
      varStat_d  = varStat_q;
      case (state_q)
         IDLE: begin
            if (inHandshake) begin
               op_d     = bus_io.op;
               maxAcc_d = bus_io.in_data;
               minAcc_d = bus_io.in_data;
               sumAcc_d = {{LOG2N{1'b0}}, bus_io.in_data};
               sqAcc_d  = {{LOG2N{1'b0}}, sampleSq};
               count_d  = CNT_W'(1);
            end
         end
         ACCUM: begin
            if (inHandshake) begin
               if (bus_io.in_data > maxAcc_q) maxAcc_d = bus_io.in_data;
               if (bus_io.in_data < minAcc_q) minAcc_d = bus_io.in_data;
               sumAcc_d = sumAcc_q + {{LOG2N{1'b0}}, bus_io.in_data};
               sqAcc_d  = sqAcc_q + {{LOG2N{1'b0}}, sampleSq};
               count_d  = count_q + CNT_W'(1);
            end
         end
         CALC: begin
            maxStat_d  = maxAcc_q;
            minStat_d  = minAcc_q;
            meanStat_d = sumAcc_q[LOG2N +: WIDTH];
            varStat_d  = varFull[2*LOG2N +: RES_W];
         end
         DONE: begin
            if (bus_io.out_ready) count_d = '0;
         end
         default: count_d = '0;
      endcase
   end

   // Datapath registers; reset discards any partial frame or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maxAcc_q   <= '0;
         minAcc_q   <= '0;
         sumAcc_q   <= '0;
         sqAcc_q    <= '0;
         count_q    <= '0;
         op_q       <= '0;
         maxStat_q  <= '0;
         minStat_q  <= '0;
         meanStat_q <= '0;
         varStat_q  <= '0;
      end else begin
         maxAcc_q   <= maxAcc_d;
         minAcc_q   <= minAcc_d;
         sumAcc_q   <= sumAcc_d;
         sqAcc_q    <= sqAcc_d;
         count_q    <= count_d;
         op_q       <= op_d;
         maxStat_q  <= maxStat_d;
         minStat_q  <= minStat_d;
         meanStat_q <= meanStat_d;
         varStat_q  <= varStat_d;
      end
   end

   // Result selection by priority on the op latched with the first sample.
   // The statistics registers only change in CALC, so result and tag are
   // stable for the whole of DONE.
   always_comb begin
      bus_io.result = '0;
      bus_io.max_f  = 1'b0;
      bus_io.min_f  = 1'b0;
      bus_io.mean_f = 1'b0;
      bus_io.var_f  = 1'b0;
      if (op_q[3]) begin
         bus_io.result = {{WIDTH{1'b0}}, maxStat_q};
         bus_io.max_f  = 1'b1;
      end else if (op_q[2]) begin
         bus_io.result = {{WIDTH{1'b0}}, minStat_q};
         bus_io.min_f  = 1'b1;
      end else if (op_q[1]) begin
         bus_io.result = {{WIDTH{1'b0}}, meanStat_q};
         bus_io.mean_f = 1'b1;
      end else if (op_q[0]) begin
         bus_io.result = varStat_q;
         bus_io.var_f  = 1'b1;
      end
   end

endmodule

// File: doc/stat_stream_calc.md
# stat_stream_calc

Sequential, parametrised statistics engine. Accepts a frame of `COUNT` unsigned samples over a valid/ready stream, accumulates max, min, sum and sum-of-squares, then returns one selected statistic (Max, Min, Mean or Var) on a valid/ready result port with a one-hot flag identifying it. It replaces the combinational four-sample calculator in the statistics datapath, adding configurable width and frame depth, back-pressure on both sides and frame-by-frame operation.

## Interface
- `WIDTH`, default 4: sample width in bits, unsigned, ≥ 2.
- `COUNT`, default 4: samples per frame; power of two, ≥ 2. `LOG2N = log2(COUNT)`.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  sample present on `in_data`.
- `in_ready`  output  1  block can accept a sample.
- `in_data`  input  WIDTH  unsigned sample.
- `op`  input  4  statistic select, priority-encoded: bit3 Max, bit2 Min, bit1 Mean, bit0 Var.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer accepts result.
- `result`  output  2*WIDTH  selected statistic, zero-extended.
- `max_f`, `min_f`, `mean_f`, `var_f`  output  1 each  one-hot tag of `result`; all 0 if `op` was 0.

## Operation
- Clocking and reset: one clock, `clk`. Reset is asynchronous, active-low on `rst_n`.
- Reset values: state IDLE; `in_ready`=1, `out_valid`=0, `result`=0, all flags 0; accumulators and sample counter 0.
- FSM states: IDLE, ACCUM, CALC, DONE.
- IDLE: `in_ready`=1. On a handshake (`in_valid & in_ready`):
  - latch `op`;
  - load max = min = sample, sum = sample, sumsq = sample²;
  - set count = 1 and go to ACCUM.
- ACCUM: `in_ready`=1. On each handshake:
  - max = larger of max and sample; min = smaller of min and sample;
  - sum += sample; sumsq += sample²; count++.
  - The handshake that makes count = `COUNT` moves the FSM to CALC.
  - `op` is ignored after the first sample of a frame.
- CALC: `in_ready`=0, one cycle. Register all four statistics:
  - Max, Min: zero-extended.
  - Mean = sum >> LOG2N (floor), zero-extended.
  - Var = (COUNT·sumsq − sum²) >> (2·LOG2N) (floor). This is never negative and always fits in 2·WIDTH bits.
  - Go to DONE.
- DONE: `out_valid`=1 and `result` and flags are held stable. On `out_ready` the FSM goes to IDLE. `in_ready` stays 0 throughout DONE.
- Result selection (priority on the latched `op`):
  - bit3 set: Max;
  - else bit2: Min;
  - else bit1: Mean;
  - else bit0: Var;
  - `op` = 0: `result` = 0, all flags 0, `out_valid` still asserted.
- Width rules:
  - sum is WIDTH+LOG2N bits.
  - sumsq is 2·WIDTH+LOG2N bits.
  - The Var intermediate is 2·WIDTH+2·LOG2N bits.
  - No accumulator ever saturates or wraps within a frame.
- Counter: LOG2N+1 bits, cleared when the FSM enters IDLE.

## Timing
- Input throughput: one sample per cycle while `in_valid` is held.
- Latency: last sample handshake at edge t, CALC during t..t+1, `out_valid` high after edge t+1 (two edges after the last-sample edge).
- Minimum frame period: COUNT + 2 cycles with `out_ready` tied high.
- The cycle after the `out_valid & out_ready` edge: `out_valid`=0 and `in_ready`=1. A sample presented in that cycle starts the next frame.
- Back-pressure: an `in_valid` gap does not change state or accumulators. `out_ready` low holds DONE indefinitely.
- `rst_n` asserted mid-frame or in DONE: the partial frame or pending result is discarded immediately and all outputs return to reset values asynchronously.
- `in_valid` while in CALC or DONE: ignored, because `in_ready`=0.

## Test plan
- WIDTH=4, COUNT=4, `op`=4'b0010, samples 3,7,1,5 -> `result`=4, `mean_f`=1; `out_valid` asserted two edges after the 4th handshake.
- Same samples repeated for `op` = 4'b1000, 4'b0100, 4'b0001 -> results 7, 1 and 5 respectively (Var = (336−256)/16), each with the matching flag.
- Samples 0,15,0,15 with `op`=4'b1111 -> `result`=15 and `max_f`=1 (priority). Same frame with `op`=4'b0001 -> `result`=56.
- All samples 15 with Var selected -> 0. `op`=0 -> `result`=0, flags 0, `out_valid`=1.
- Random `in_valid` gaps, and `out_ready` held low for 5 cycles -> `result` stable while held, `in_ready`=0 in DONE, the next frame is computed correctly after release. `op` changed mid-frame has no effect.
- Reset pulse after the 2nd sample -> all outputs return to reset values. The following full frame 3,7,1,5 with Mean selected -> 4.
- WIDTH=8, COUNT=16, 8 samples of 0 and 8 of 255 -> Var = 16256 (16-bit result), Mean = 127.
